lsu_ctrl: RTL

Load/store unit controller at the EX/WB boundary of the ri5cy core. It accepts one load/store strobe per instruction and drives a req/gnt/rvalid data-memory port. It aligns and extends load data and returns it with the destination register. It generates `valid_lsu_load_o`, the completion pulse that releases the pipeline control unit from its load stall.

---
 rtl/lsu_ctrl_if.sv | 25 ++
 rtl/lsu_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl_if.sv
// Data-memory req/gnt/rvalid port of the load/store unit.
// master = LSU side, slave = memory side.
interface lsu_ctrl_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 32
);
  logic                      data_req;
  logic                      data_gnt;
  logic                      data_rvalid;
  logic [MEM_ADDR_WIDTH-1:0] data_addr;
  logic                      data_we;
  logic [3:0]                data_be;
  logic [DATA_WIDTH-1:0]     data_wdata;
  logic [DATA_WIDTH-1:0]     data_rdata;

  modport master (
    output data_req, data_addr, data_we, data_be, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_addr, data_we, data_be, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: drives the data-memory port, aligns/extends load data,
// pulses valid_lsu_load_o to release the load stall. Optional macro: LSU_MISALIGN_ERR_EN.
module lsu_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned MEM_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid_i,
  input  logic                      req_we_i,
  input  logic [1:0]                req_size_i,
  input  logic                      req_unsigned_i,
  input  logic [MEM_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [ADDR_WIDTH-1:0]     req_rd_i,
  output logic                      busy_o,
  lsu_ctrl_if.master                mem,
  output logic                      valid_lsu_load_o,
  output logic                      load_we_o,
  output logic [ADDR_WIDTH-1:0]     load_rd_o,
  output logic [DATA_WIDTH-1:0]     load_rdata_o,
  output logic                      err_o
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, RESP} state_e;

  state_e                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      we_q, we_d;
  logic [3:0]                be_q, be_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [1:0]                size_q, size_d;
  logic                      uns_q, uns_d;
  logic [ADDR_WIDTH-1:0]     rd_q, rd_d;
  logic [1:0]                off_q, off_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      resp_we_q, resp_we_d;

  logic [3:0]                strobe_be;
  logic [DATA_WIDTH-1:0]     strobe_wdata;
  logic [MEM_ADDR_WIDTH-1:0] strobe_addr;
  logic                      misaligned;
  logic [4:0]                shamt;
  logic [DATA_WIDTH-1:0]     shifted;
  logic [DATA_WIDTH-1:0]     load_ext;

`ifdef LSU_MISALIGN_ERR_EN
  assign misaligned = (req_size_i == 2'b01 && req_addr_i[0]) ||
                      (req_size_i[1] && req_addr_i[1:0] != 2'b00);
  assign err_o      = (state_q == IDLE) && req_valid_i && misaligned;
`else
  assign misaligned = 1'b0;
  assign err_o      = 1'b0;
`endif

  assign strobe_addr = {req_addr_i[MEM_ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    strobe_be    = 4'b1111;
    strobe_wdata = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        strobe_be    = 4'b0001 << req_addr_i[1:0];
        strobe_wdata = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        strobe_be    = req_addr_i[1] ? 4'b1100 : 4'b0011;
        strobe_wdata = {2{req_wdata_i[15:0]}};
      end
      default: begin
        strobe_be    = 4'b1111;
        strobe_wdata = req_wdata_i;
      end
    endcase
  end

  // Extraction uses only the captured size/offset; its result is registered before leaving.
  always_comb begin
    case (size_q)
      2'b00:   shamt = {off_q, 3'b000};
      2'b01:   shamt = {off_q[1], 4'b0000};
      default: shamt = 5'd0;
    endcase
    shifted = data_rdata_shift(mem.data_rdata, shamt);
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  function automatic logic [DATA_WIDTH-1:0] data_rdata_shift(input logic [DATA_WIDTH-1:0] d,
                                                             input logic [4:0] sh);
    return d >> sh;
  endfunction

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    we_d           = we_q;
    be_d           = be_q;
    wdata_d        = wdata_q;
    size_d         = size_q;
    uns_d          = uns_q;
    rd_d           = rd_q;
    off_d          = off_q;
    rdata_d        = rdata_q;
    resp_we_d      = resp_we_q;
    mem.data_req   = 1'b0;
    mem.data_addr  = '0;
    mem.data_we    = 1'b0;
    mem.data_be    = '0;
    mem.data_wdata = '0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = strobe_addr;
          we_d    = req_we_i;
          be_d    = strobe_be;
          wdata_d = strobe_wdata;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          rd_d    = req_rd_i;
          off_d   = req_addr_i[1:0];
          if (misaligned) begin
            // Misaligned load still completes so the stall releases, but without a write.
            if (!req_we_i) begin
              rdata_d   = '0;
              resp_we_d = 1'b0;
              state_d   = RESP;
            end
          end else begin
            mem.data_req   = 1'b1;
            mem.data_addr  = strobe_addr;
            mem.data_we    = req_we_i;
            mem.data_be    = strobe_be;
            mem.data_wdata = strobe_wdata;
            if (mem.data_gnt) state_d = req_we_i ? IDLE : WAIT_RVALID;
            else              state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        mem.data_req   = 1'b1;
        mem.data_addr  = addr_q;
        mem.data_we    = we_q;
        mem.data_be    = be_q;
        mem.data_wdata = wdata_q;
        if (mem.data_gnt) state_d = we_q ? IDLE : WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (mem.data_rvalid) begin
          rdata_d   = load_ext;
          resp_we_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      rd_q      <= '0;
      off_q     <= '0;
      rdata_q   <= '0;
      resp_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      rd_q      <= rd_d;
      off_q     <= off_d;
      rdata_q   <= rdata_d;
      resp_we_q <= resp_we_d;
    end
  end

  assign busy_o           = (state_q != IDLE);
  assign valid_lsu_load_o = (state_q == RESP);
  assign load_we_o        = (state_q == RESP) && resp_we_q;
  assign load_rd_o        = (state_q == RESP) ? rd_q : '0;
  assign load_rdata_o     = (state_q == RESP) ? rdata_q : '0;

endmodule
